crc_owner_arbiter: RTL and testbench

CRC_OWNER_ARBITER -- requirements
Module: crc_owner_arbiter

---
 rtl/crc_arb_pkg.sv | 14 +
 rtl/crc_arb_timeout.sv | 59 +++++
 rtl/crc_owner_arbiter.sv | 138 +++++++++++++
 tb/tb_crc_owner_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/crc_arb_pkg.sv
// rtl/crc_arb_pkg.sv - shared state encoding and defaults for the CRC engine owner arbiter
package crc_arb_pkg;

    localparam int TIMEOUT_CYCLES_DEFAULT = 255;

    typedef enum logic [2:0] {
        IDLE,
        HAND_SEAL,
        SEAL,
        HAND_CPU,
        CPU
    } arb_state_t;

endpackage

// File: rtl/crc_arb_timeout.sv
// rtl/crc_arb_timeout.sv - idle-owner revoke counter and requester masks (used under CRC_ARB_TIMEOUT_EN)
import crc_arb_pkg::*;

module crc_arb_timeout #(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  arb_state_t i_state,
    input  logic       i_seal_req,
    input  logic       i_cpu_req,
    input  logic       i_seal_dv,
    input  logic       i_cpu_dv,
    output logic       o_expire,
    output logic       o_timeout_pulse,
    output logic       o_seal_mask,
    output logic       o_cpu_mask
);

    localparam logic [7:0] LP_LIMIT = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] r_count;
    logic       r_pulse;
    logic       r_seal_mask;
    logic       r_cpu_mask;
    logic       w_owned;
    logic       w_owner_req;
    logic       w_owner_dv;

    assign w_owned     = (i_state == SEAL) || (i_state == CPU);
    assign w_owner_req = (i_state == SEAL) ? i_seal_req : i_cpu_req;
    assign w_owner_dv  = (i_state == SEAL) ? i_seal_dv  : i_cpu_dv;

    // A release in the expiry cycle is a normal hand-back, not a revoke.
    assign o_expire = w_owned && w_owner_req && !w_owner_dv && (r_count == LP_LIMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count     <= 8'd0;
            r_pulse     <= 1'b0;
            r_seal_mask <= 1'b0;
            r_cpu_mask  <= 1'b0;
        end else begin
            if (w_owned && !w_owner_dv) begin
                r_count <= r_count + 8'd1;
            end else begin
                r_count <= 8'd0;
            end
            r_pulse     <= o_expire;
            r_seal_mask <= (o_expire && (i_state == SEAL)) || (r_seal_mask && i_seal_req);
            r_cpu_mask  <= (o_expire && (i_state == CPU))  || (r_cpu_mask  && i_cpu_req);
        end
    end

    assign o_timeout_pulse = r_pulse;
    assign o_seal_mask     = r_seal_mask;
    assign o_cpu_mask      = r_cpu_mask;

endmodule

// File: rtl/crc_owner_arbiter.sv
// rtl/crc_owner_arbiter.sv - seal/CPU ownership arbiter for a shared CRC engine; CRC_ARB_TIMEOUT_EN adds idle revoke
import crc_arb_pkg::*;

module crc_owner_arbiter #(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       seal_req,
    input  logic       seal_crc_init,
    input  logic [7:0] seal_crc_byte,
    input  logic       seal_crc_feed,
    input  logic       cpu_req,
    input  logic       crc_peri_init,
    input  logic [7:0] crc_peri_data,
    input  logic       crc_peri_dv,
    output logic       seal_gnt,
    output logic       cpu_gnt,
    output logic       seal_using_crc,
    output logic       crc_engine_init,
    output logic [7:0] crc_engine_data,
    output logic       crc_engine_dv,
    output logic       timeout_pulse
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES out of range 2..255");
    end

    arb_state_t r_state;
    arb_state_t w_next;
    logic       r_seal_gnt;
    logic       r_cpu_gnt;
    logic       r_seal_using;
    logic       w_expire;
    logic       w_pulse;
    logic       w_seal_mask;
    logic       w_cpu_mask;
    logic       w_seal_req;
    logic       w_cpu_req;

`ifdef CRC_ARB_TIMEOUT_EN
    crc_arb_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk             (clk),
        .rst             (rst),
        .i_state         (r_state),
        .i_seal_req      (seal_req),
        .i_cpu_req       (cpu_req),
        .i_seal_dv       (seal_crc_feed),
        .i_cpu_dv        (crc_peri_dv),
        .o_expire        (w_expire),
        .o_timeout_pulse (w_pulse),
        .o_seal_mask     (w_seal_mask),
        .o_cpu_mask      (w_cpu_mask)
    );
`else
    assign w_expire    = 1'b0;
    assign w_pulse     = 1'b0;
    assign w_seal_mask = 1'b0;
    assign w_cpu_mask  = 1'b0;
`endif

    assign w_seal_req = seal_req && !w_seal_mask;
    assign w_cpu_req  = cpu_req  && !w_cpu_mask;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_seal_req) begin
                    w_next = HAND_SEAL;
                end else if (w_cpu_req) begin
                    w_next = HAND_CPU;
                end
            end
            HAND_SEAL: w_next = SEAL;
            HAND_CPU:  w_next = CPU;
            SEAL: begin
                if (!w_seal_req) begin
                    w_next = w_cpu_req ? HAND_CPU : IDLE;
                end else if (w_expire) begin
                    w_next = IDLE;
                end
            end
            CPU: begin
                if (!w_cpu_req) begin
                    w_next = w_seal_req ? HAND_SEAL : IDLE;
                end else if (w_expire) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Grants and mux select are registered alongside the state so they drop with it on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_seal_gnt   <= 1'b0;
            r_cpu_gnt    <= 1'b0;
            r_seal_using <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_seal_gnt   <= (w_next == SEAL);
            r_cpu_gnt    <= (w_next == CPU);
            r_seal_using <= (w_next == SEAL) || (w_next == HAND_SEAL);
        end
    end

    always_comb begin
        crc_engine_init = 1'b0;
        crc_engine_data = 8'd0;
        crc_engine_dv   = 1'b0;
        case (r_state)
            HAND_SEAL, HAND_CPU: crc_engine_init = 1'b1;
            SEAL: begin
                crc_engine_init = seal_crc_init;
                crc_engine_data = seal_crc_byte;
                crc_engine_dv   = seal_crc_feed;
            end
            CPU: begin
                crc_engine_init = crc_peri_init;
                crc_engine_data = crc_peri_data;
                crc_engine_dv   = crc_peri_dv;
            end
            default: ;
        endcase
    end

    assign seal_gnt       = r_seal_gnt;
    assign cpu_gnt        = r_cpu_gnt;
    assign seal_using_crc = r_seal_using;
    assign timeout_pulse  = w_pulse;

endmodule

// File: tb/tb_crc_owner_arbiter.sv
// tb/tb_crc_owner_arbiter.sv - directed plus random checks of crc_owner_arbiter against an ownership model
module tb_crc_owner_arbiter;

`ifdef CRC_ARB_TIMEOUT_EN
    localparam int T     = 4;
    localparam bit TO_EN = 1'b1;
`else
    localparam int T     = 255;
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       seal_req, seal_crc_init, seal_crc_feed;
    logic [7:0] seal_crc_byte;
    logic       cpu_req, crc_peri_init, crc_peri_dv;
    logic [7:0] crc_peri_data;
    logic       seal_gnt, cpu_gnt, seal_using_crc;
    logic       crc_engine_init, crc_engine_dv, timeout_pulse;
    logic [7:0] crc_engine_data;

    int total = 0;
    int bad   = 0;

    // Ownership model: who holds the engine, whether this is its fresh-init cycle,
    // how long it has gone without a data beat, and which requesters are locked out.
    int m_owner;
    bit m_fresh, m_pulse, m_smask, m_cmask;
    int m_run;

    crc_owner_arbiter #(.TIMEOUT_CYCLES(T)) dut (
        .clk             (clk),
        .rst             (rst),
        .seal_req        (seal_req),
        .seal_crc_init   (seal_crc_init),
        .seal_crc_byte   (seal_crc_byte),
        .seal_crc_feed   (seal_crc_feed),
        .cpu_req         (cpu_req),
        .crc_peri_init   (crc_peri_init),
        .crc_peri_data   (crc_peri_data),
        .crc_peri_dv     (crc_peri_dv),
        .seal_gnt        (seal_gnt),
        .cpu_gnt         (cpu_gnt),
        .seal_using_crc  (seal_using_crc),
        .crc_engine_init (crc_engine_init),
        .crc_engine_data (crc_engine_data),
        .crc_engine_dv   (crc_engine_dv),
        .timeout_pulse   (timeout_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_owner = 0; m_fresh = 0; m_pulse = 0; m_smask = 0; m_cmask = 0; m_run = 0;
    endtask

    task automatic model_step();
        bit sr, cr, oreq, odv, other, rv_s, rv_c;
        if (rst) begin
            m_reset();
            return;
        end
        sr = seal_req && !m_smask;
        cr = cpu_req && !m_cmask;
        rv_s = 0; rv_c = 0;
        if (m_owner == 0) begin
            if (sr) begin m_owner = 1; m_fresh = 1; end
            else if (cr) begin m_owner = 2; m_fresh = 1; end
        end else if (m_fresh) begin
            m_fresh = 0; m_run = 0;
        end else begin
            oreq  = (m_owner == 1) ? sr : cr;
            odv   = (m_owner == 1) ? seal_crc_feed : crc_peri_dv;
            other = (m_owner == 1) ? cr : sr;
            if (!oreq) begin
                if (other) begin m_owner = 3 - m_owner; m_fresh = 1; end
                else m_owner = 0;
            end else if (TO_EN && !odv && m_run == T - 1) begin
                if (m_owner == 1) rv_s = 1; else rv_c = 1;
                m_owner = 0;
            end else if (odv) m_run = 0;
            else m_run++;
        end
        m_pulse = rv_s || rv_c;
        m_smask = rv_s || (m_smask && seal_req);
        m_cmask = rv_c || (m_cmask && cpu_req);
    endtask

    task automatic check_outputs();
        logic       e_init, e_dv;
        logic [7:0] e_data;
        e_init = 0; e_dv = 0; e_data = 8'd0;
        if (m_owner != 0 && m_fresh) e_init = 1;
        else if (m_owner == 1) begin e_init = seal_crc_init; e_data = seal_crc_byte; e_dv = seal_crc_feed; end
        else if (m_owner == 2) begin e_init = crc_peri_init; e_data = crc_peri_data; e_dv = crc_peri_dv; end
        chk("seal_gnt", seal_gnt, m_owner == 1 && !m_fresh);
        chk("cpu_gnt", cpu_gnt, m_owner == 2 && !m_fresh);
        chk("seal_using_crc", seal_using_crc, m_owner == 1);
        chk("engine_init", crc_engine_init, e_init);
        chk("engine_data", crc_engine_data, e_data);
        chk("engine_dv", crc_engine_dv, e_dv);
        chk("timeout_pulse", timeout_pulse, m_pulse);
        chk("gnt_onehot", seal_gnt && cpu_gnt, 1'b0);
    endtask

    task automatic cycle();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_seal_gnt"}, seal_gnt, 1'b0);
        chk({tag, "_cpu_gnt"}, cpu_gnt, 1'b0);
        chk({tag, "_using"}, seal_using_crc, 1'b0);
        chk({tag, "_init"}, crc_engine_init, 1'b0);
        chk({tag, "_data"}, crc_engine_data, 8'd0);
        chk({tag, "_dv"}, crc_engine_dv, 1'b0);
        chk({tag, "_pulse"}, timeout_pulse, 1'b0);
    endtask

    initial begin
        rst = 1; seal_req = 0; seal_crc_init = 0; seal_crc_byte = 8'h00; seal_crc_feed = 0;
        cpu_req = 0; crc_peri_init = 0; crc_peri_data = 8'h00; crc_peri_dv = 0;
        m_reset();
        #2;
        chk_all_zero("reset");
        cycle(); cycle();
        rst = 0;
        cycle();

        // Simultaneous requests: seal wins, handoff cycle, then grant.
        seal_req = 1; cpu_req = 1; seal_crc_byte = 8'h77; crc_peri_data = 8'h55; crc_peri_dv = 1;
        cycle();
        chk("both_hand_init", crc_engine_init, 1'b1);
        chk("both_hand_using", seal_using_crc, 1'b1);
        chk("both_hand_data", crc_engine_data, 8'h00);
        cycle();
        chk("both_seal_gnt", seal_gnt, 1'b1);
        chk("both_cpu_gnt", cpu_gnt, 1'b0);
        seal_req = 0; crc_peri_dv = 0;
        cycle(); cycle(); cycle();

        // CPU owns while the seal side drives its own data.
        chk("cpu_owns", cpu_gnt, 1'b1);
        crc_peri_data = 8'hA5; crc_peri_dv = 1; seal_crc_byte = 8'h3C; seal_crc_feed = 1; seal_req = 1;
        #1;
        chk("cpu_data", crc_engine_data, 8'hA5);
        chk("cpu_dv", crc_engine_dv, 1'b1);
        chk("cpu_using", seal_using_crc, 1'b0);
        cycle();

        // CPU releases with seal waiting: single fresh-init handoff.
        cpu_req = 0;
        cycle();
        chk("h2s_init", crc_engine_init, 1'b1);
        chk("h2s_dv", crc_engine_dv, 1'b0);
        chk("h2s_gnt", seal_gnt, 1'b0);
        seal_crc_feed = 1;
        cycle();
        chk("h2s_seal_gnt", seal_gnt, 1'b1);
        seal_crc_feed = 0;

`ifdef CRC_ARB_TIMEOUT_EN
        cycle(); cycle(); cycle();
        chk("to_still_gnt", seal_gnt, 1'b1);
        chk("to_no_pulse", timeout_pulse, 1'b0);
        cycle();
        chk("to_revoked", seal_gnt, 1'b0);
        chk("to_pulse", timeout_pulse, 1'b1);
        cycle();
        chk("to_pulse_one", timeout_pulse, 1'b0);
        cycle(); cycle(); cycle();
        chk("to_masked", seal_gnt || seal_using_crc, 1'b0);
        seal_req = 0;
        cycle();
        seal_req = 1;
        cycle(); cycle();
        chk("to_regrant", seal_gnt, 1'b1);
`else
        for (int i = 0; i < 300; i++) cycle();
        chk("hold_seal_gnt", seal_gnt, 1'b1);
        chk("hold_no_pulse", timeout_pulse, 1'b0);
`endif

        // Asynchronous reset while seal owns.
        seal_crc_feed = 1; seal_crc_byte = 8'h9E;
        cycle();
        chk("pre_rst_gnt", seal_gnt, 1'b1);
        #2;
        rst = 1;
        m_reset();
        #1;
        chk_all_zero("async_rst");
        cycle();
        rst = 0; seal_req = 0; seal_crc_feed = 0; cpu_req = 1;
        cycle();
        chk("post_rst_hand", cpu_gnt, 1'b0);
        cycle();
        chk("post_rst_cpu_gnt", cpu_gnt, 1'b1);

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(5) == 0) seal_req = ~seal_req;
            if ($urandom_range(5) == 0) cpu_req = ~cpu_req;
            seal_crc_init = ($urandom_range(7) == 0);
            crc_peri_init = ($urandom_range(7) == 0);
            seal_crc_byte = 8'($urandom);
            crc_peri_data = 8'($urandom);
            seal_crc_feed = ($urandom_range(3) == 0);
            crc_peri_dv   = ($urandom_range(3) == 0);
            if ($urandom_range(199) == 0) begin
                rst = 1;
                m_reset();
            end else begin
                rst = 0;
            end
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
